// File: rtl/hamming_dec.sv
// Two-stage pipelined SECDED decoder for the extended Hamming (8,4) code.
// Stage 1 captures the codeword with its syndrome/parity; stage 2 corrects and classifies.
module hamming_dec #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic             err_corr,
  output logic             err_uncorr,
  output logic [2:0]       syndrome,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic       adv1, adv2;
  logic [2:0] syn_in;
  logic       par_in;

  logic       s1_valid_q;
  logic [7:0] s1_code_q;
  logic [2:0] s1_syn_q;
  logic       s1_par_q;

  logic       out_valid_q;
  logic [3:0] data_q;
  logic       err_corr_q;
  logic       err_uncorr_q;
  logic [2:0] syndrome_q;

  logic [CNT_W-1:0] corr_cnt_q;
  logic [CNT_W-1:0] uncorr_cnt_q;

  logic [7:0] flip;
  logic [3:0] corr_data;
  logic       is_corr;
  logic       is_uncorr;
  logic       load2;

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;
  assign load2    = adv2 && s1_valid_q;

  assign syn_in[0] = code_in[0] ^ code_in[4] ^ code_in[5] ^ code_in[7];
  assign syn_in[1] = code_in[1] ^ code_in[4] ^ code_in[6] ^ code_in[7];
  assign syn_in[2] = code_in[2] ^ code_in[5] ^ code_in[6] ^ code_in[7];
  assign par_in    = ^code_in;

  // Odd overall parity means exactly one flipped bit; syndrome 0 points at the parity bit.
  always_comb begin
    flip = '0;
    if (s1_par_q) begin
      unique case (s1_syn_q)
        3'd0: flip[3] = 1'b1;
        3'd1: flip[0] = 1'b1;
        3'd2: flip[1] = 1'b1;
        3'd3: flip[4] = 1'b1;
        3'd4: flip[2] = 1'b1;
        3'd5: flip[5] = 1'b1;
        3'd6: flip[6] = 1'b1;
        3'd7: flip[7] = 1'b1;
      endcase
    end
  end

  assign corr_data = s1_code_q[7:4] ^ flip[7:4];
  assign is_corr   = s1_par_q;
  assign is_uncorr = !s1_par_q && (s1_syn_q != 3'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_code_q <= code_in;
        s1_syn_q  <= syn_in;
        s1_par_q  <= par_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      data_q       <= '0;
      err_corr_q   <= 1'b0;
      err_uncorr_q <= 1'b0;
      syndrome_q   <= '0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_q       <= corr_data;
        err_corr_q   <= is_corr;
        err_uncorr_q <= is_uncorr;
        syndrome_q   <= s1_syn_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (clr_cnt) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      if (load2 && is_corr && (corr_cnt_q != CntMax)) begin
        corr_cnt_q <= corr_cnt_q + CntOne;
      end
      if (load2 && is_uncorr && (uncorr_cnt_q != CntMax)) begin
        uncorr_cnt_q <= uncorr_cnt_q + CntOne;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out   = data_q;
  assign err_corr   = err_corr_q;
  assign err_uncorr = err_uncorr_q;
  assign syndrome   = syndrome_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_dec.sv
// Directed bench for hamming_dec: scoreboard of expected decodes built from a
// brute-force nearest-codeword model, plus handshake, counter and reset checks.
module tb_hamming_dec;

  localparam int unsigned CW = 2;
  localparam int unsigned CntSat = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    code_in;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    data_out;
  logic          err_corr;
  logic          err_uncorr;
  logic [2:0]    syndrome;
  logic          clr_cnt;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;

  hamming_dec #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .code_in    (code_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .err_corr   (err_corr),
    .err_uncorr (err_uncorr),
    .syndrome   (syndrome),
    .clr_cnt    (clr_cnt),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic       c;
    logic       u;
    logic [2:0] s;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_corr = 0;
  int   exp_uncorr = 0;

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic c0, c1, c2, p;
    c0 = d[0] ^ d[1] ^ d[3];
    c1 = d[0] ^ d[2] ^ d[3];
    c2 = d[1] ^ d[2] ^ d[3];
    p  = ^{d, c2, c1, c0};
    return {d, p, c2, c1, c0};
  endfunction

  function automatic bit is_cw(input logic [7:0] w);
    return enc(w[7:4]) == w;
  endfunction

  // Nearest-codeword search: independent of the syndrome-to-bit mapping.
  function automatic exp_t model(input logic [7:0] w);
    exp_t       e;
    logic [7:0] t;
    e.s[0] = w[0] ^ w[4] ^ w[5] ^ w[7];
    e.s[1] = w[1] ^ w[4] ^ w[6] ^ w[7];
    e.s[2] = w[2] ^ w[5] ^ w[6] ^ w[7];
    e.d = w[7:4];
    e.c = 1'b0;
    e.u = 1'b0;
    if (!is_cw(w)) begin
      e.u = 1'b1;
      for (int i = 0; i < 8; i++) begin
        t = w ^ (8'd1 << i);
        if (is_cw(t)) begin
          e.d = t[7:4];
          e.c = 1'b1;
          e.u = 1'b0;
        end
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: compare any output transfer, then push any accepted input.
  task automatic step();
    bit   acc_in;
    exp_t e;
    #1;
    acc_in = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("data_out", 32'(data_out), 32'(e.d));
        chk("err_corr", 32'(err_corr), 32'(e.c));
        chk("err_uncorr", 32'(err_uncorr), 32'(e.u));
        chk("syndrome", 32'(syndrome), 32'(e.s));
      end
    end
    @(posedge clk);
    if (acc_in) begin
      e = model(code_in);
      q.push_back(e);
      if (e.c && exp_corr < int'(CntSat)) exp_corr++;
      if (e.u && exp_uncorr < int'(CntSat)) exp_uncorr++;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] w);
    in_valid = 1'b1;
    code_in  = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_corr_cnt"}, 32'(corr_cnt), 32'(exp_corr));
    chk({tag, "_uncorr_cnt"}, 32'(uncorr_cnt), 32'(exp_uncorr));
  endtask

  task automatic clear();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    exp_corr = 0;
    exp_uncorr = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; code_in = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk_cnt("rst");
    @(negedge clk);

    // Clean words, 2-cycle latency on the first.
    send(8'hB1);
    #1 chk("lat_b1_c1", 32'(out_valid), 32'd0);
    step();
    #1 chk("lat_b1_c2", 32'(out_valid), 32'd1);
    send(8'h00);
    drain();
    chk_cnt("clean");

    send(8'h91);
    drain();
    chk_cnt("single");
    send(8'h90);
    drain();
    chk_cnt("double");

    // All single flips of B1 at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'hB1 ^ (8'd1 << i));
    drain();
    chk_cnt("sweep");

    clear();
    chk_cnt("clr");

    // Saturation at 3 with 5 single-error words.
    for (int i = 0; i < 5; i++) send(8'hB1 ^ (8'd1 << i));
    drain();
    chk_cnt("sat");

    // Clear coinciding with an increment: clear wins.
    send(8'h91);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    exp_corr = 0;
    exp_uncorr = 0;
    drain();
    chk_cnt("clr_vs_inc");

    // Backpressure.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    code_in   = 8'hB1; step();
    code_in   = 8'h91; step();
    code_in   = 8'h90;
    #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(data_out), 32'hB);
      chk("bp_hold_corr", 32'(err_corr), 32'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("bp_burst_valid", 32'(out_valid), 32'd1);
      step();
    end
    chk("bp_queue_empty", 32'(q.size()), 32'd0);
    #1 chk("bp_after_valid", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Reset mid-stream with two words in flight.
    clear();
    in_valid = 1'b1;
    code_in  = 8'h91; step();
    code_in  = 8'hB1; step();
    in_valid = 1'b0;
    #1 chk_cnt("pre_rst");
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data_out", 32'(data_out), 32'd0);
    chk("mid_rst_syndrome", 32'(syndrome), 32'd0);
    chk("mid_rst_err_corr", 32'(err_corr), 32'd0);
    chk("mid_rst_corr_cnt", 32'(corr_cnt), 32'd0);
    q.delete();
    exp_corr = 0;
    exp_uncorr = 0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    send(8'hB1);
    #1 chk("post_rst_lat_c1", 32'(out_valid), 32'd0);
    step();
    #1 chk("post_rst_lat_c2", 32'(out_valid), 32'd1);
    drain();
    chk_cnt("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
